// File: rtl/lcd_pic_layer.sv
// Image layer: overlays a ROM image at a movable origin onto a background pixel stream,
// with power-of-two upscaling and colour-key transparency.
// Latency ROM_LAT+2 clocks, input to pix_data/img_hit. Accepts a pixel every cycle, no stall.
//
// Ports:
//   clk_in, sys_rst       pixel clock, synchronous active-high reset
//   pix_x, pix_y, bg_data current coordinate and the background pixel at that coordinate
//   layer_en_in, org_x_in, org_y_in, org_we
//                         pending enable/origin, written by org_we, applied at frame start
//   rom_addr, rom_data    registered image ROM address and its data ROM_LAT clocks later
//   pix_data, img_hit     composited pixel, and whether it came from the image
module lcd_pic_layer #(
  parameter int                IMG_WIDTH  = 345,
  parameter int                IMG_HEIGHT = 249,
  parameter int                ADDR_W     = 17,
  parameter int                DATA_W     = 24,
  parameter int                ROM_LAT    = 1,
  parameter int                SCALE_SH   = 0,
  parameter int                ORIGIN_X   = 100,
  parameter int                ORIGIN_Y   = 150,
  parameter int                KEY_EN     = 1,
  parameter logic [DATA_W-1:0] KEY_COLOR  = 24'hFF00FF
) (
  input  logic              clk_in,
  input  logic              sys_rst,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  input  logic [DATA_W-1:0] bg_data,
  input  logic              layer_en_in,
  input  logic [10:0]       org_x_in,
  input  logic [10:0]       org_y_in,
  input  logic              org_we,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              img_hit
);

  // Scaled image extent; 14 bits so origin + span never overflows (max 2047 + 8*345).
  localparam logic [13:0] SPAN_X = 14'(IMG_WIDTH << SCALE_SH);
  localparam logic [13:0] SPAN_Y = 14'(IMG_HEIGHT << SCALE_SH);

  logic [10:0] act_x, act_y, pend_x, pend_y;
  logic        act_en, pend_en;

  // Origin/enable in force for the current pixel. On the frame-start pixel the
  // pending values (or ones being written this very cycle) already take effect,
  // so the whole new frame, including (0,0), is drawn with one origin.
  logic        frame_start;
  logic [10:0] eff_x, eff_y;
  logic        eff_en;

  always_comb begin
    frame_start = (pix_x == 11'd0) && (pix_y == 11'd0);
    eff_x  = act_x;
    eff_y  = act_y;
    eff_en = act_en;
    if (frame_start) begin
      if (org_we) begin
        eff_x  = org_x_in;
        eff_y  = org_y_in;
        eff_en = layer_en_in;
      end else begin
        eff_x  = pend_x;
        eff_y  = pend_y;
        eff_en = pend_en;
      end
    end
  end

  // Hit test in widened unsigned arithmetic: windows running past 2047 simply clip.
  logic [13:0]       x_w, y_w, ox_w, oy_w;
  logic              hit;
  logic [10:0]       dx, dy;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    x_w  = {3'b000, pix_x};
    y_w  = {3'b000, pix_y};
    ox_w = {3'b000, eff_x};
    oy_w = {3'b000, eff_y};
    hit  = eff_en && (x_w >= ox_w) && (x_w < ox_w + SPAN_X)
                  && (y_w >= oy_w) && (y_w < oy_w + SPAN_Y);
    // Offsets are only meaningful on a hit; the address is forced to 0 otherwise.
    dx = (pix_x - eff_x) >> SCALE_SH;
    dy = (pix_y - eff_y) >> SCALE_SH;
    addr_next = '0;
    if (hit) begin
      addr_next = ADDR_W'(dy) * ADDR_W'(IMG_WIDTH) + ADDR_W'(dx);
    end
  end

  // Origin and enable shadow registers.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      act_x   <= 11'(ORIGIN_X);
      act_y   <= 11'(ORIGIN_Y);
      act_en  <= 1'b1;
      pend_x  <= 11'(ORIGIN_X);
      pend_y  <= 11'(ORIGIN_Y);
      pend_en <= 1'b1;
    end else begin
      if (org_we) begin
        pend_x  <= org_x_in;
        pend_y  <= org_y_in;
        pend_en <= layer_en_in;
      end
      if (frame_start) begin
        act_x  <= eff_x;
        act_y  <= eff_y;
        act_en <= eff_en;
      end
    end
  end

  // Index 0 is stage A; index ROM_LAT lines up with rom_data for the same pixel.
  logic              hit_sr [0:ROM_LAT];
  logic [DATA_W-1:0] bg_sr  [0:ROM_LAT];
  logic              keyed;

  always_comb begin
    keyed = (KEY_EN != 0) && (rom_data == KEY_COLOR);
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      rom_addr <= '0;
      pix_data <= '0;
      img_hit  <= 1'b0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        hit_sr[i] <= 1'b0;
        bg_sr[i]  <= '0;
      end
    end else begin
      rom_addr  <= addr_next;
      hit_sr[0] <= hit;
      bg_sr[0]  <= bg_data;
      for (int i = 1; i <= ROM_LAT; i++) begin
        hit_sr[i] <= hit_sr[i-1];
        bg_sr[i]  <= bg_sr[i-1];
      end
      if (hit_sr[ROM_LAT] && !keyed) begin
        pix_data <= rom_data;
        img_hit  <= 1'b1;
      end else begin
        pix_data <= bg_sr[ROM_LAT];
        img_hit  <= 1'b0;
      end
    end
  end

endmodule
